fm_meas_engine: RTL and testbench
=================================

Name: fm_meas_engine

Overview:
- Parametrised measurement back-end for the FM demodulator output.
- Replaces the ad-hoc max-only peak tracking with a proper windowed measurement pipeline:
  - min/max tracking gives Vpp;
  - zero-crossing timing with hysteresis gives modulation frequency;
  - a shared iterative divider gives delta_f and the modulation index mf.
- Sits after the demod FIR chain and feeds the display/UART reporting logic.

Parameters:
- DATA_W, 11: signed width of demod_in.
- CLK_HZ, 32000000: clock frequency in Hz, used for frequency scaling.
- WIN_LEN, 65536: valid samples per measurement window; minimum 128.
- HYST, 8: zero-crossing hysteresis in counts.
- KDEV, 1000: frequency-deviation gain in Hz per count of Vpp, scaled by 2^KDEV_SHIFT.
- KDEV_SHIFT, 0: right shift applied after the KDEV multiply.
- F_W, 16: width of mod_freq and delta_f in Hz.
- MF_FRAC, 4: fractional bits of mf.
- MF_W, 8: width of mf.

Ports:
- clk_32m  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  measurement enable; low aborts the current window.
- demod_in  in  DATA_W  signed demodulated sample.
- in_valid  in  1  demod_in qualifier.
- vpp  out  DATA_W+1  unsigned peak-to-peak of the last completed window.
- mod_freq  out  F_W  modulation frequency in Hz.
- delta_f  out  F_W  peak frequency deviation in Hz.
- mf  out  MF_W  modulation index, unsigned, MF_FRAC fractional bits.
- sig_ok  out  1  last window had at least 2 rising crossings.
- meas_valid  out  1  one-cycle pulse when all outputs update together.

Behaviour:
- Reset (async assert, sync deassert expected upstream):
  - all outputs 0;
  - centre = 0;
  - all accumulators cleared;
  - FSM enters ACC.
- Accumulation runs in ACC only while en=1. Each in_valid sample:
  - updates max and min (the first sample of a window loads both);
  - increments the sample count.
- A 32-bit cycle timer runs every clock while en=1.
- Crossing detector:
  - state LO/HI, starts LO;
  - LO→HI when sample > centre+HYST; this counts one rising crossing;
  - HI→LO when sample < centre−HYST.
  - First crossing latches t_first. Every crossing latches t_last and increments N; N saturates at 2^16−1.
- Window end, on the WIN_LEN-th valid sample:
  - snapshot max, min, N, t_first, t_last into compute registers;
  - centre ← (max+min)>>>1;
  - clear the accumulators;
  - the next window starts on the following sample.
  - Accumulation is continuous; the compute path works on the snapshot.
- FSM, compute path: IDLE → DIV_F → DIV_MF → UPD → IDLE.
  - DIV_F: if N<2 or t_last==t_first, the quotient is 0 and the state skips the divider. Otherwise a 48-bit restoring divider, one bit per cycle (48 cycles), computes q = (N−1)·CLK_HZ / (t_last−t_first).
  - delta_f is computed combinationally in DIV_F: dv = (vpp·KDEV) >> (KDEV_SHIFT+1), saturated to 2^F_W−1.
  - DIV_MF: if mod_freq==0, mf = 2^MF_W−1. Otherwise the divider computes (dv << MF_FRAC)/freq, saturated to 2^MF_W−1.
  - UPD: register vpp, mod_freq (saturated to F_W bits), delta_f, mf and sig_ok; pulse meas_valid for 1 cycle.
  - Latency from the window-end sample to meas_valid is at most 100 cycles.
- A window end arriving while the compute path is busy is impossible, since WIN_LEN ≥ 128; the implementation need not handle it.
- en falling:
  - accumulators, detector state and timer are cleared at once;
  - an in-flight computation completes normally;
  - outputs hold their values.
- en rising: a fresh window starts and centre is retained.
- Reset mid-window or mid-divide: everything aborts and no meas_valid is issued.
- Arithmetic:
  - vpp = max − min, computed in DATA_W+1 bits, never negative;
  - all divides are floor divides.

Test Plan:
- Parameters WIN_LEN=64000, KDEV=50. Stimulus: square wave ±100, period 3200 clocks, in_valid=1 every cycle.
  Required response: meas_valid once per window with vpp=200, mod_freq=10000, delta_f=5000, mf=8 (0.5 in Q4), sig_ok=1.
- DC input 37 for 2 windows → mod_freq=0, mf=255, sig_ok=0, vpp=0, delta_f=0.
- Noise ±5 about 0 with HYST=8 → N=0; no false crossings; sig_ok=0.
- KDEV=60000 with vpp=1000 → delta_f saturates at 65535 and mf saturates at 255.
- en dropped halfway through a window, then restored → no meas_valid for the aborted window; the next full window reports correct values.
- rst_n asserted during DIV_F → all outputs 0 immediately; no meas_valid until a full window completes after release.

Source files
------------

// File: rtl/fm_meas_engine.sv
// fm_meas_engine: windowed Vpp, zero-crossing frequency, deviation and modulation-index measurement.
module fm_meas_engine #(
  parameter int DATA_W     = 11,
  parameter int CLK_HZ     = 32000000,
  parameter int WIN_LEN    = 65536,
  parameter int HYST       = 8,
  parameter int KDEV       = 1000,
  parameter int KDEV_SHIFT = 0,
  parameter int F_W        = 16,
  parameter int MF_FRAC    = 4,
  parameter int MF_W       = 8
) (
  input  logic                     clk_32m,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] demod_in,
  input  logic                     in_valid,
  output logic [DATA_W:0]          vpp,
  output logic [F_W-1:0]           mod_freq,
  output logic [F_W-1:0]           delta_f,
  output logic [MF_W-1:0]          mf,
  output logic                     sig_ok,
  output logic                     meas_valid
);
  localparam int CW = $clog2(WIN_LEN);
  typedef enum logic [1:0] {ACC, DIV_F, DIV_MF, UPD} state_t;
  state_t st;
  logic signed [DATA_W-1:0] mx, mn, centre, mx_n, mn_n;
  logic [CW-1:0] cnt;
  logic hi, rise, fall, first, last, win_end, ge, busy;
  logic [15:0] n_cr, n_n, s_n;
  logic [31:0] timer, t_first, t_last, tf_n, tl_n, s_tf, s_tl;
  logic signed [31:0] smp_x, thr_hi, thr_lo;
  logic [DATA_W:0] vpp_n, sum, s_vpp;
  logic [47:0] rem, quo, dvs, rem_n, quo_n, dvw;
  logic [48:0] t;
  logic [5:0] bcnt;
  logic [F_W-1:0] freq, dv, q_fsat;
  logic [MF_W-1:0] mf_r, q_msat;
  always_comb begin
    first   = cnt == '0;
    last    = cnt == CW'(WIN_LEN - 1);
    win_end = en && in_valid && last;
    mx_n    = (first || demod_in > mx) ? demod_in : mx;
    mn_n    = (first || demod_in < mn) ? demod_in : mn;
    smp_x   = 32'(demod_in);
    thr_hi  = 32'(centre) + HYST;
    thr_lo  = 32'(centre) - HYST;
    rise    = !hi && smp_x > thr_hi;
    fall    = hi && smp_x < thr_lo;
    n_n     = (rise && n_cr != 16'hFFFF) ? n_cr + 16'd1 : n_cr;
    tf_n    = (rise && n_cr == 16'd0) ? timer : t_first;
    tl_n    = rise ? timer : t_last;
    vpp_n   = {mx_n[DATA_W-1], mx_n} - {mn_n[DATA_W-1], mn_n};
    sum     = {mx_n[DATA_W-1], mx_n} + {mn_n[DATA_W-1], mn_n};
    dvw     = (48'(s_vpp) * 48'(KDEV)) >> (KDEV_SHIFT + 1);
    dv      = |dvw[47:F_W] ? '1 : dvw[F_W-1:0];
    // restoring divide step: quo shifts the dividend out and the quotient in
    t       = {rem, quo[47]};
    ge      = t >= {1'b0, dvs};
    rem_n   = ge ? 48'(t - {1'b0, dvs}) : t[47:0];
    quo_n   = {quo[46:0], ge};
    q_fsat  = |quo_n[47:F_W] ? '1 : quo_n[F_W-1:0];
    q_msat  = |quo_n[47:MF_W] ? '1 : quo_n[MF_W-1:0];
  end
  always_ff @(posedge clk_32m or negedge rst_n) begin
    if (!rst_n) begin
      {mx, mn, centre, cnt, hi, n_cr, t_first, t_last, timer} <= '0;
    end else if (!en) begin
      {mx, mn, cnt, hi, n_cr, t_first, t_last, timer} <= '0;
    end else begin
      timer <= timer + 32'd1;
      if (in_valid) begin
        hi      <= rise ? 1'b1 : fall ? 1'b0 : hi;
        cnt     <= last ? '0 : cnt + CW'(1);
        mx      <= mx_n;
        mn      <= mn_n;
        n_cr    <= last ? '0 : n_n;
        t_first <= last ? '0 : tf_n;
        t_last  <= last ? '0 : tl_n;
        centre  <= last ? sum[DATA_W:1] : centre;
      end
    end
  end
  always_ff @(posedge clk_32m or negedge rst_n) begin
    if (!rst_n) begin
      st <= ACC;
      {busy, bcnt, rem, quo, dvs, freq, mf_r, s_vpp, s_n, s_tf, s_tl} <= '0;
      {vpp, mod_freq, delta_f, mf, sig_ok, meas_valid} <= '0;
    end else begin
      meas_valid <= 1'b0;
      if (busy) begin
        rem  <= rem_n;
        quo  <= quo_n;
        bcnt <= bcnt - 6'd1;
      end
      case (st)
        ACC: if (win_end) begin
          s_vpp <= vpp_n;
          s_n   <= n_n;
          s_tf  <= tf_n;
          s_tl  <= tl_n;
          st    <= DIV_F;
        end
        DIV_F: if (!busy) begin
          if (s_n < 16'd2 || s_tl == s_tf) begin
            freq <= '0;
            st   <= DIV_MF;
          end else begin
            quo  <= 48'(s_n - 16'd1) * 48'(CLK_HZ);
            rem  <= '0;
            dvs  <= {16'd0, s_tl - s_tf};
            bcnt <= 6'd47;
            busy <= 1'b1;
          end
        end else if (bcnt == 6'd0) begin
          busy <= 1'b0;
          freq <= q_fsat;
          st   <= DIV_MF;
        end
        DIV_MF: if (!busy) begin
          if (freq == '0) begin
            mf_r <= '1;
            st   <= UPD;
          end else begin
            quo  <= 48'(dv) << MF_FRAC;
            rem  <= '0;
            dvs  <= 48'(freq);
            bcnt <= 6'd47;
            busy <= 1'b1;
          end
        end else if (bcnt == 6'd0) begin
          busy <= 1'b0;
          mf_r <= q_msat;
          st   <= UPD;
        end
        UPD: begin
          vpp        <= s_vpp;
          mod_freq   <= freq;
          delta_f    <= dv;
          mf         <= mf_r;
          sig_ok     <= s_n >= 16'd2;
          meas_valid <= 1'b1;
          st         <= ACC;
        end
        default: st <= ACC;
      endcase
    end
  end
endmodule

// File: tb/tb_fm_meas_engine.sv
// tb_fm_meas_engine: directed windows on two gain settings, scoreboard-checked on meas_valid.
module tb_fm_meas_engine;
  logic clk_32m = 1'b0, rst_n = 1'b0, en = 1'b0, in_valid = 1'b0;
  logic signed [10:0] demod_in = '0;
  logic [11:0] vpp1, vpp2;
  logic [15:0] f1, f2, d1, d2;
  logic [7:0] mf1, mf2;
  logic ok1, ok2, mv1, mv2;
  int checks = 0, failures = 0;
  typedef struct {int vpp; int f; int d; int mf; int ok;} exp_t;
  exp_t q1[$], q2[$];

  always #5 clk_32m = ~clk_32m;

  fm_meas_engine #(.CLK_HZ(320000), .WIN_LEN(640), .KDEV(50)) u_dut (
    .clk_32m(clk_32m), .rst_n(rst_n), .en(en), .demod_in(demod_in), .in_valid(in_valid),
    .vpp(vpp1), .mod_freq(f1), .delta_f(d1), .mf(mf1), .sig_ok(ok1), .meas_valid(mv1));
  fm_meas_engine #(.CLK_HZ(320000), .WIN_LEN(640), .KDEV(60000)) u_sat (
    .clk_32m(clk_32m), .rst_n(rst_n), .en(en), .demod_in(demod_in), .in_valid(in_valid),
    .vpp(vpp2), .mod_freq(f2), .delta_f(d2), .mf(mf2), .sig_ok(ok2), .meas_valid(mv2));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input int v, input int f, input int d, input int m, input int o);
    chk({tag, ".vpp"}, v, e.vpp);
    chk({tag, ".mod_freq"}, f, e.f);
    chk({tag, ".delta_f"}, d, e.d);
    chk({tag, ".mf"}, m, e.mf);
    chk({tag, ".sig_ok"}, o, e.ok);
  endtask

  task automatic zeros(input string tag);
    cmp({tag, "_dut"}, '{0, 0, 0, 0, 0}, int'(vpp1), int'(f1), int'(d1), int'(mf1), int'(ok1));
    cmp({tag, "_sat"}, '{0, 0, 0, 0, 0}, int'(vpp2), int'(f2), int'(d2), int'(mf2), int'(ok2));
  endtask

  // kind 0 square (period per), 1 DC, 2 alternating noise; one sample per clock
  task automatic drive(input int kind, input int amp, input int per, input int n);
    for (int k = 0; k < n; k++) begin
      demod_in = 11'(kind == 0 ? ((k % per) < per / 2 ? amp : -amp) : kind == 1 ? amp : (k % 2 == 1 ? -amp : amp));
      in_valid = 1'b1;
      @(posedge clk_32m);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic expect_win(input int v, input int f, input int dd1, input int m1, input int dd2, input int m2, input int o);
    q1.push_back('{v, f, dd1, m1, o});
    q2.push_back('{v, f, dd2, m2, o});
  endtask

  always @(negedge clk_32m) begin
    if (mv1) begin
      if (q1.size() == 0) chk("dut_unexpected_meas_valid", 1, 0);
      else cmp("dut", q1.pop_front(), int'(vpp1), int'(f1), int'(d1), int'(mf1), int'(ok1));
    end
    if (mv2) begin
      if (q2.size() == 0) chk("sat_unexpected_meas_valid", 1, 0);
      else cmp("sat", q2.pop_front(), int'(vpp2), int'(f2), int'(d2), int'(mf2), int'(ok2));
    end
  end

  initial begin
    repeat (3) @(posedge clk_32m);
    #1;
    zeros("reset");
    rst_n = 1'b1;
    @(posedge clk_32m);
    #1;
    en = 1'b1;
    repeat (2) begin
      expect_win(200, 10000, 5000, 8, 65535, 104, 1);
      drive(0, 100, 32, 640);
    end
    repeat (2) begin
      expect_win(0, 0, 0, 255, 0, 255, 0);
      drive(1, 37, 1, 640);
    end
    repeat (2) begin
      expect_win(10, 0, 250, 255, 65535, 255, 0);
      drive(2, 5, 1, 640);
    end
    expect_win(1000, 2500, 25000, 160, 65535, 255, 1);
    drive(0, 500, 128, 640);
    // abandoned half window, then a clean one
    drive(0, 100, 32, 320);
    en = 1'b0;
    repeat (16) @(posedge clk_32m);
    #1;
    en = 1'b1;
    expect_win(200, 10000, 5000, 8, 65535, 104, 1);
    drive(0, 100, 32, 640);
    // this window is killed by reset while dividing
    drive(0, 100, 32, 640);
    repeat (3) @(posedge clk_32m);
    #1;
    rst_n = 1'b0;
    #1;
    zeros("mid_reset");
    repeat (3) @(posedge clk_32m);
    #1;
    rst_n = 1'b1;
    expect_win(200, 10000, 5000, 8, 65535, 104, 1);
    drive(0, 100, 32, 640);
    for (int i = 0; i < 300 && (q1.size() != 0 || q2.size() != 0); i++) @(posedge clk_32m);
    repeat (20) @(posedge clk_32m);
    chk("dut_pending", q1.size(), 0);
    chk("sat_pending", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
